sram_arbiter: RTL

Two-port arbiter that shares the single SLC-3 SRAM between the CPU memory path (MAR/MDR side of the memory-mapped I/O subsystem) and a second requester, the program loader/debug port. It serializes requests, owns the SRAM strobes (OE, WE, active-low), stretches each access to a fixed number of cycles, and returns read data with a one-cycle acknowledge. The CPU has priority, and a starvation counter guarantees loader progress.

---
 rtl/sram_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port SRAM arbiter, CPU priority with loader anti-starvation
//
// Purpose:
//   Shares one asynchronous SRAM between the CPU memory path and the program
//   loader/debug port. Each access is serialized as IDLE -> ACCESS (strobe held
//   ACCESS_CYCLES cycles) -> DONE (strobes released, one-cycle ack). The CPU
//   wins simultaneous requests unless the loader has already been passed over
//   MAX_WAIT times in a row.
//
// Ports:
//   Clk, Reset                  clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request; held stable until cpu_ack
//   cpu_rdata, cpu_ack          CPU read data (valid with ack), one-cycle ack
//   ldr_req/we/addr/wdata       loader request; same contract as the CPU port
//   ldr_rdata, ldr_ack          loader read data, one-cycle ack
//   ADDR, Data_to_SRAM          registered SRAM address / write data
//   Data_from_SRAM              SRAM read data
//   OE, WE                      registered SRAM strobes, active-low
//   owner                       0=CPU, 1=loader; current or last grant

module sram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_WAIT      = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              OE,
  output logic              WE,
  output logic              owner
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int STV_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              owner_q, owner_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ldr_ack_q, ldr_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic              grant_ldr;
  logic              sel_we;

  // Loader takes the slot when it is alone, or when the CPU has already been
  // granted MAX_WAIT consecutive times while the loader was waiting.
  assign grant_ldr = ldr_req && (!cpu_req || (starve_q == STV_MAX));
  assign sel_we    = grant_ldr ? ldr_we : cpu_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    owner_d     = owner_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (!ldr_req) begin
          starve_d = '0;
        end
        if (cpu_req || ldr_req) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_LOAD;
          owner_d = grant_ldr;
          wr_d    = sel_we;
          // Both strobes come from the single direction bit, so they can
          // never be low together.
          oe_n_d  = sel_we;
          we_n_d  = !sel_we;
          if (grant_ldr) begin
            addr_d   = ldr_addr;
            wdata_d  = ldr_wdata;
            starve_d = '0;
          end else begin
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            if (ldr_req && (starve_q != STV_MAX)) begin
              starve_d = starve_q + STV_W'(1);
            end
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          // Last strobe edge: sample read data while OE is still low, then
          // release both strobes for the turnaround cycle.
          state_d = ST_DONE;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (owner_q) begin
            ldr_ack_d = 1'b1;
            if (!wr_q) begin
              ldr_rdata_d = Data_from_SRAM;
            end
          end else begin
            cpu_ack_d = 1'b1;
            if (!wr_q) begin
              cpu_rdata_d = Data_from_SRAM;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      owner_q     <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      owner_q     <= owner_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign ADDR         = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign OE           = oe_n_q;
  assign WE           = we_n_q;
  assign owner        = owner_q;
  assign cpu_ack      = cpu_ack_q;
  assign ldr_ack      = ldr_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign ldr_rdata    = ldr_rdata_q;

endmodule
